// File: rtl/sico_if_rec_feeder.sv
// sico_if_rec_feeder: upstream feeder for the SiCo interface recorder.
// DUT-side words are buffered in a small FIFO and then serialised into
// OUT_WIDTH-bit beats for the recorder, least-significant slice first.
// In drop mode the DUT is never stalled. Words that arrive while the FIFO is
// full are discarded, and a saturating counter records how many were lost.
module sico_if_rec_feeder #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter int DEPTH     = 4,
  parameter int DROP_MODE = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  input  logic [IN_WIDTH-1:0]        in_data_i,
  output logic                       in_ready_o,
  output logic                       out_valid_o,
  output logic [OUT_WIDTH-1:0]       out_data_o,
  input  logic                       hold_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic [15:0]                drop_cnt_o
);

  localparam int BEATS = IN_WIDTH / OUT_WIDTH;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW    = AW + 1;

  // Reject parameter combinations the datapath cannot represent.
  generate
    if ((IN_WIDTH % OUT_WIDTH) != 0) begin : g_badWidth
      $error("sico_if_rec_feeder: IN_WIDTH must be a multiple of OUT_WIDTH");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_badDepth
      $error("sico_if_rec_feeder: DEPTH must be a power of two and >= 2");
    end
  endgenerate

  // Each pointer carries one wrap bit above the address bits, so the
  // pointer difference gives the level directly.
  logic [AW:0]           r_wrPtr;
  logic [AW:0]           r_rdPtr;
  logic [BW-1:0]         r_beat;
  logic [15:0]           r_dropCnt;
  logic [IN_WIDTH-1:0]   r_mem [DEPTH];

  logic [LW-1:0]         w_level;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_xfer;
  logic                  w_lastBeat;
  logic                  w_pop;
  logic [IN_WIDTH-1:0]   w_headWord;
  logic [BEATS-1:0][OUT_WIDTH-1:0] w_headBeats;

  assign w_level    = r_wrPtr - r_rdPtr;
  assign w_full     = (w_level == LW'(DEPTH));
  assign w_empty    = (w_level == '0);

  // A push never relies on a pop in the same cycle to free a slot.
  assign w_push     = in_valid_i && !w_full;
  assign w_drop     = (DROP_MODE != 0) && in_valid_i && w_full;

  assign w_xfer     = out_valid_o;
  assign w_lastBeat = (r_beat == BW'(BEATS - 1));
  assign w_pop      = w_xfer && w_lastBeat;

  // The head word is viewed as an array of beats so the beat counter selects
  // the slice directly. Beat 0 is the least-significant slice.
  assign w_headWord  = r_mem[r_rdPtr[AW-1:0]];
  assign w_headBeats = w_headWord;

  assign out_valid_o = !w_empty && !hold_i;
  assign out_data_o  = w_headBeats[r_beat];
  assign level_o     = w_level;
  assign drop_cnt_o  = r_dropCnt;

  // Ready is held low while in reset. Drop mode always accepts a word,
  // because overflow is absorbed by discarding rather than by stalling.
  always_comb begin
    in_ready_o = 1'b0;
    if (!rst_i) begin
      in_ready_o = (DROP_MODE != 0) ? 1'b1 : !w_full;
    end
  end

  // The storage array is cleared on reset so out_data_o never shows X,
  // even before the first word has been written.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wrPtr[AW-1:0]] <= in_data_i;
    end
  end

  // The write pointer advances on every accepted word and wraps through its
  // wrap bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wrPtr <= '0;
    end else if (w_push) begin
      r_wrPtr <= r_wrPtr + 1'b1;
    end
  end

  // The read pointer only moves once the last beat of the head word has gone.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rdPtr <= '0;
    end else if (w_pop) begin
      r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  // The beat counter steps on every transfer and wraps at the end of a word.
  // It stays frozen while hold keeps out_valid low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_beat <= '0;
    end else if (w_xfer) begin
      if (w_lastBeat) begin
        r_beat <= '0;
      end else begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  // Count discarded overflow words, saturating at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_dropCnt <= '0;
    end else if (w_drop && (r_dropCnt != 16'hFFFF)) begin
      r_dropCnt <= r_dropCnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_sico_if_rec_feeder.sv
// tb_sico_if_rec_feeder: directed checks for the recorder feeder.
// One instance runs in back-pressure mode and one runs in drop mode.
module tb_sico_if_rec_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        inValid0 = 1'b0;
  logic [31:0] inData0  = '0;
  logic        hold0    = 1'b0;
  logic        inReady0;
  logic        outValid0;
  logic [7:0]  outData0;
  logic [2:0]  level0;
  logic [15:0] drop0;

  logic        inValid1 = 1'b0;
  logic [31:0] inData1  = '0;
  logic        hold1    = 1'b0;
  logic        inReady1;
  logic        outValid1;
  logic [7:0]  outData1;
  logic [2:0]  level1;
  logic [15:0] drop1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        h;
    logic        expValid;
    logic [7:0]  expData;
    logic [2:0]  expLevel;
    logic        expReady;
  } vec_t;

  vec_t vecs[15];

  always #5 clk = ~clk;

  sico_if_rec_feeder #(.IN_WIDTH(32), .OUT_WIDTH(8), .DEPTH(4), .DROP_MODE(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(inValid0), .in_data_i(inData0),
    .in_ready_o(inReady0), .out_valid_o(outValid0), .out_data_o(outData0),
    .hold_i(hold0), .level_o(level0), .drop_cnt_o(drop0)
  );

  sico_if_rec_feeder #(.IN_WIDTH(32), .OUT_WIDTH(8), .DEPTH(4), .DROP_MODE(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(inValid1), .in_data_i(inData1),
    .in_ready_o(inReady1), .out_valid_o(outValid1), .out_data_o(outData1),
    .hold_i(hold1), .level_o(level1), .drop_cnt_o(drop1)
  );

  function automatic vec_t mk(logic v, logic [31:0] d, logic h, logic ev,
                              logic [7:0] ed, logic [2:0] el, logic er);
    vec_t r;
    r.v = v; r.d = d; r.h = h;
    r.expValid = ev; r.expData = ed; r.expLevel = el; r.expReady = er;
    return r;
  endfunction

  // Word k built from base b has the beats b+4k, b+4k+1, b+4k+2, b+4k+3.
  // A correct stream therefore produces consecutive byte values.
  function automatic logic [31:0] wordOf(logic [7:0] base, int k);
    logic [7:0] b;
    b = base + 8'(4 * k);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input vec_t t);
    @(negedge clk);
    inValid0 = t.v;
    inData0  = t.d;
    hold0    = t.h;
    #1;
    checkOutput($sformatf("vec%0d valid", idx), outValid0, t.expValid);
    checkOutput($sformatf("vec%0d level", idx), level0, t.expLevel);
    checkOutput($sformatf("vec%0d ready", idx), inReady0, t.expReady);
    if (t.expValid) checkOutput($sformatf("vec%0d data", idx), outData0, t.expData);
  endtask

  // Push words sentStart..nWords-1 into dut0 and check that every beat of
  // words 0..nWords-1 comes out in order. The push side and the beat check
  // advance independently, and the whole run is bounded by a cycle budget.
  task automatic runStream(input string name, input int sentStart, input int nWords,
                           input bit randHold, input logic [7:0] base, input int budget);
    int sent = sentStart;
    int got  = 0;
    int cyc  = 0;
    bit levelOk = 1'b1;
    while ((got < nWords * 4) && (cyc < budget)) begin
      @(negedge clk);
      hold0    = randHold ? ($urandom_range(0, 3) == 0) : 1'b0;
      inValid0 = (sent < nWords);
      inData0  = wordOf(base, sent);
      #1;
      if (level0 > 3'd4) levelOk = 1'b0;
      if (outValid0) begin
        checkOutput($sformatf("%s beat%0d", name, got), outData0, 32'(base + 8'(got)));
        got++;
      end
      if (inValid0 && inReady0) sent++;
      cyc++;
    end
    @(negedge clk);
    inValid0 = 1'b0;
    hold0    = 1'b0;
    #1;
    checkOutput({name, " beat count"}, got, nWords * 4);
    checkOutput({name, " words pushed"}, sent, nWords);
    checkOutput({name, " level bound"}, levelOk, 1'b1);
    checkOutput({name, " drained"}, level0, 3'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    checkOutput("reset ready0", inReady0, 1'b0);
    checkOutput("reset valid0", outValid0, 1'b0);
    checkOutput("reset level0", level0, 3'd0);
    checkOutput("reset ready1", inReady1, 1'b0);
    checkOutput("reset drop1", drop1, 16'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Basic serialise of 0xAABBCCDD, then hold for 3 cycles after beat 0 of 0x11223344.
    vecs[0]  = mk(1'b1, 32'hAABBCCDD, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1);
    vecs[1]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 8'hDD, 3'd1, 1'b1);
    vecs[2]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 8'hCC, 3'd1, 1'b1);
    vecs[3]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 8'hBB, 3'd1, 1'b1);
    vecs[4]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 8'hAA, 3'd1, 1'b1);
    vecs[5]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 8'h00, 3'd0, 1'b1);
    vecs[6]  = mk(1'b1, 32'h11223344, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1);
    vecs[7]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 8'h44, 3'd1, 1'b1);
    vecs[8]  = mk(1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 3'd1, 1'b1);
    vecs[9]  = mk(1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 3'd1, 1'b1);
    vecs[10] = mk(1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 3'd1, 1'b1);
    vecs[11] = mk(1'b0, 32'h0,        1'b0, 1'b1, 8'h33, 3'd1, 1'b1);
    vecs[12] = mk(1'b0, 32'h0,        1'b0, 1'b1, 8'h22, 3'd1, 1'b1);
    vecs[13] = mk(1'b0, 32'h0,        1'b0, 1'b1, 8'h11, 3'd1, 1'b1);
    vecs[14] = mk(1'b0, 32'h0,        1'b0, 1'b0, 8'h00, 3'd0, 1'b1);
    for (int i = 0; i < 15; i++) applyStimulus(i, vecs[i]);

    // Back-pressure: hold, fill the FIFO with 4 words, and stall the 5th word.
    hold0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      inValid0 = 1'b1;
      inData0  = wordOf(8'h50, k);
      #1;
      checkOutput($sformatf("bp ready%0d", k), inReady0, 1'b1);
    end
    @(negedge clk);
    inData0 = wordOf(8'h50, 4);
    #1;
    checkOutput("bp level full", level0, 3'd4);
    checkOutput("bp ready stall", inReady0, 1'b0);
    checkOutput("bp valid held", outValid0, 1'b0);
    runStream("bp", 4, 5, 1'b0, 8'h50, 100);

    // Long stream with random hold, so the pointers wrap several times.
    runStream("wrap", 0, 20, 1'b1, 8'h80, 400);

    // Drop mode: with hold active, 6 pushes leave 4 stored words and 2 dropped.
    hold1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      inValid1 = 1'b1;
      inData1  = wordOf(8'h10, k);
      #1;
      checkOutput($sformatf("drop ready%0d", k), inReady1, 1'b1);
    end
    @(negedge clk);
    inValid1 = 1'b0;
    #1;
    checkOutput("drop level", level1, 3'd4);
    checkOutput("drop count", drop1, 16'd2);
    begin
      int got = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        hold1 = 1'b0;
        #1;
        if (outValid1) begin
          if (got < 16) checkOutput($sformatf("drop beat%0d", got), outData1, 32'(8'h10 + 8'(got)));
          got++;
        end
      end
      checkOutput("drop beat count", got, 16);
      checkOutput("drop drained", level1, 3'd0);
    end

    // Async reset mid-word: store 2 words, send one beat, then reset between edges.
    @(negedge clk);
    hold0 = 1'b1; inValid0 = 1'b1; inData0 = wordOf(8'hA0, 0);
    @(negedge clk);
    inData0 = wordOf(8'hA0, 1);
    @(negedge clk);
    inValid0 = 1'b0; hold0 = 1'b0;
    #1;
    checkOutput("rst pre level", level0, 3'd2);
    checkOutput("rst pre beat", outData0, 8'hA0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst valid0", outValid0, 1'b0);
    checkOutput("rst level0", level0, 3'd0);
    checkOutput("rst ready0", inReady0, 1'b0);
    checkOutput("rst drop1", drop1, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    inValid0 = 1'b1; inData0 = 32'h01020304;
    @(negedge clk);
    inValid0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput($sformatf("post rst valid%0d", i), outValid0, 1'b1);
      checkOutput($sformatf("post rst beat%0d", i), outData0, 32'(8'h04 - 8'(i)));
      @(negedge clk);
    end
    #1;
    checkOutput("post rst idle", outValid0, 1'b0);
    checkOutput("post rst level", level0, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
